// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundle of the request, response and ALU-side signals of
// alu_arbiter.
//   r0_* / r1_*  : requester valid/ready handshake, operands, 4-bit ALU control
//   rsp_*        : shared ID-tagged response channel (valid/ready, result, flags, err)
//   alu_*        : registered operands/control to the ALU and its registered outputs
// Modports:
//   slave  - the arbiter's view (accepts requests, produces responses, drives the ALU)
//   master - the environment's view (requesters, response consumer, ALU)
interface alu_arbiter_if;
    logic        r0_valid;
    logic        r0_ready;
    logic [31:0] r0_src1;
    logic [31:0] r0_src2;
    logic [3:0]  r0_ctrl;

    logic        r1_valid;
    logic        r1_ready;
    logic [31:0] r1_src1;
    logic [31:0] r1_src2;
    logic [3:0]  r1_ctrl;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_cout;
    logic        rsp_overflow;
    logic        rsp_err;

    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_cout;
    logic        alu_overflow;

    modport slave (
        input  r0_valid, r0_src1, r0_src2, r0_ctrl,
        output r0_ready,
        input  r1_valid, r1_src1, r1_src2, r1_ctrl,
        output r1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err,
        input  rsp_ready,
        output alu_src1, alu_src2, alu_ctrl,
        input  alu_result, alu_zero, alu_cout, alu_overflow
    );

    modport master (
        output r0_valid, r0_src1, r0_src2, r0_ctrl,
        input  r0_ready,
        output r1_valid, r1_src1, r1_src2, r1_ctrl,
        input  r1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err,
        output rsp_ready,
        input  alu_src1, alu_src2, alu_ctrl,
        output alu_result, alu_zero, alu_cout, alu_overflow
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter/sequencer for the shared
// 32-bit registered ALU (one-cycle latency). One operation in flight at a time.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   bus    - alu_arbiter_if.slave: r0_*/r1_* requests, rsp_* response, alu_* ALU side
// Flow: IDLE (accept, latch operands) -> EXEC (ALU registers result) -> RESP
// (result/flags passed through from the ALU until rsp_ready).
// Optional feature: define ALU_ARB_OPCHECK_EN to reject illegal ALU control
// codes; such a request skips EXEC and answers one cycle after accept with
// rsp_err=1, zero result/flags, and the alu_* registers untouched.
module alu_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    logic        last_grant;
    logic        grant_id;
    logic        err_q;
    logic [31:0] alu_src1_q;
    logic [31:0] alu_src2_q;
    logic [3:0]  alu_ctrl_q;

    logic        gnt;
    logic        accept;
    logic [31:0] sel_src1;
    logic [31:0] sel_src2;
    logic [3:0]  sel_ctrl;
    logic        sel_illegal;
    logic        in_resp;

    // Round robin: a tie goes to the requester that did not win last time.
    always_comb begin
        gnt = 1'b0;
        if (bus.r1_valid && !bus.r0_valid)
            gnt = 1'b1;
        else if (bus.r1_valid && bus.r0_valid)
            gnt = ~last_grant;
    end

    // Gated by rst_n so ready is low while reset is held.
    assign accept       = rst_n && (state == IDLE) && (bus.r0_valid || bus.r1_valid);
    assign bus.r0_ready = accept && !gnt;
    assign bus.r1_ready = accept &&  gnt;

    assign sel_src1 = gnt ? bus.r1_src1 : bus.r0_src1;
    assign sel_src2 = gnt ? bus.r1_src2 : bus.r0_src2;
    assign sel_ctrl = gnt ? bus.r1_ctrl : bus.r0_ctrl;

`ifdef ALU_ARB_OPCHECK_EN
    function automatic logic legal_ctrl(input logic [3:0] c);
        case (c)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: legal_ctrl = 1'b1;
            default:                                              legal_ctrl = 1'b0;
        endcase
    endfunction
    assign sel_illegal = !legal_ctrl(sel_ctrl);
`else
    assign sel_illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            err_q      <= 1'b0;
            alu_src1_q <= '0;
            alu_src2_q <= '0;
            alu_ctrl_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_id   <= gnt;
                        last_grant <= gnt;
                        if (sel_illegal) begin
                            // Nothing goes to the ALU; answer straight away.
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            err_q      <= 1'b0;
                            alu_src1_q <= sel_src1;
                            alu_src2_q <= sel_src2;
                            alu_ctrl_q <= sel_ctrl;
                            state      <= EXEC;
                        end
                    end
                end
                EXEC: state <= RESP;
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                        err_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alu_src1 = alu_src1_q;
    assign bus.alu_src2 = alu_src2_q;
    assign bus.alu_ctrl = alu_ctrl_q;

    // Response data is a gated passthrough of the ALU's registered outputs;
    // the alu_* operands are held in RESP, so it stays stable under backpressure.
    assign in_resp          = (state == RESP);
    assign bus.rsp_valid    = in_resp;
    assign bus.rsp_id       = in_resp && grant_id;
    assign bus.rsp_result   = (in_resp && !err_q) ? bus.alu_result : 32'h0;
    assign bus.rsp_zero     = in_resp && !err_q && bus.alu_zero;
    assign bus.rsp_cout     = in_resp && !err_q && bus.alu_cout;
    assign bus.rsp_overflow = in_resp && !err_q && bus.alu_overflow;
`ifdef ALU_ARB_OPCHECK_EN
    assign bus.rsp_err      = in_resp && err_q;
`else
    assign bus.rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a small
// registered ALU model on the alu_* side. Stimulus pushes the hand-computed
// response at accept time; a negedge monitor compares on each handshake and
// checks first-response latency.
module tb_alu_arbiter;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    alu_arbiter_if bus();

    alu_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered ALU: bit3 invert A, bit2 invert B + carry-in, 1:0 AND/OR/ADD/SLT.
    logic [31:0] m_a, m_b, m_res;
    logic [32:0] m_sum;
    logic        m_ovf;
    always_comb begin
        m_a   = bus.alu_ctrl[3] ? ~bus.alu_src1 : bus.alu_src1;
        m_b   = bus.alu_ctrl[2] ? ~bus.alu_src2 : bus.alu_src2;
        m_sum = {1'b0, m_a} + {1'b0, m_b} + {32'h0, bus.alu_ctrl[2]};
        m_ovf = (m_a[31] == m_b[31]) && (m_sum[31] != m_a[31]);
        case (bus.alu_ctrl[1:0])
            2'b00:   m_res = m_a & m_b;
            2'b01:   m_res = m_a | m_b;
            2'b10:   m_res = m_sum[31:0];
            default: m_res = {31'h0, m_sum[31] ^ m_ovf};
        endcase
    end
    always @(posedge clk) begin
        bus.alu_result   <= m_res;
        bus.alu_zero     <= (m_res == 32'h0);
        bus.alu_cout     <= m_sum[32];
        bus.alu_overflow <= m_ovf;
    end

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [3:0]  flg;   // {zero, cout, overflow, err}
        int          acc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   acc_log[$];
    int   acc_cyc[$];
    bit   hold_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: latency on the first valid cycle, data on the handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else if (bus.rsp_valid) begin
            if (!hold_prev) begin
                if (sbq.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
                else chk("rsp_latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
            end
            if (bus.rsp_ready && sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                chk("rsp_result", 64'(bus.rsp_result), 64'(e.res));
                chk("rsp_flags", 64'({bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow, bus.rsp_err}),
                    64'(e.flg));
            end
            hold_prev = !bus.rsp_ready;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic drive(input bit id, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
        if (id) begin
            bus.r1_valid = v; bus.r1_src1 = a; bus.r1_src2 = b; bus.r1_ctrl = c;
        end else begin
            bus.r0_valid = v; bus.r0_src1 = a; bus.r0_src2 = b; bus.r0_ctrl = c;
        end
    endtask

    // Called just after a posedge; returns just after a posedge.
    task automatic do_req(input bit id, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input logic [31:0] er, input logic [3:0] ef,
                          input bit keep);
        bit got;
        exp_t e;
        got = 1'b0;
        drive(id, 1'b1, a, b, c);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (id ? bus.r1_ready : bus.r0_ready) got = 1'b1;
        end
        if (!got) begin
            chk(id ? "r1_accept_timeout" : "r0_accept_timeout", 64'd0, 64'd1);
        end else begin
            e.id = id; e.res = er; e.flg = ef; e.acc = cyc; e.lat = ef[0] ? 1 : 2;
            sbq.push_back(e);
            acc_log.push_back(int'(id));
            acc_cyc.push_back(cyc);
        end
        @(posedge clk); #1;
        if (!keep || !got) drive(id, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
        #1;
    endtask

    task automatic chk_zero_outputs(input string name);
        chk(name, 64'({bus.r0_ready, bus.r1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_zero,
                       bus.rsp_cout, bus.rsp_overflow, bus.rsp_err}), 64'd0);
        chk({name, "_data"}, {bus.rsp_result, bus.alu_src1}, 64'd0);
        chk({name, "_alu"}, 64'({bus.alu_src2, bus.alu_ctrl}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    bit bg_done;

    initial begin
        cyc = 0; checks = 0; errors = 0; hold_prev = 1'b0;
        rst_n = 1'b0;
        bus.rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 32'h1234, 32'h5678, 4'h2);   // valid during reset must not be readied
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // r0 ADD 5+3 -> 8, response in C2, idle again in C3.
        do_req(1'b0, 32'h5, 32'h3, 4'b0010, 32'h8, 4'b0000, 1'b0);
        @(negedge clk);                                  // C1
        chk("exec_no_rsp", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);                                  // C2 (monitor checks data)
        @(negedge clk);                                  // C3
        chk("c3_idle", 64'(bus.rsp_valid), 64'd0);
        chk("alu_ctrl_add", 64'(bus.alu_ctrl), 64'h2);
        @(posedge clk); #1;

        // r1 SUB 0x7FFFFFFF - 0xFFFFFFFF -> 0x80000000, overflow.
        do_req(1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 4'b0110, 32'h80000000, 4'b0010, 1'b0);
        drain();

        // Both hold valid for 4 ops: order 0,1,0,1, 3 cycles apart.
        acc_log.delete(); acc_cyc.delete();
        @(posedge clk); #1;
        fork
            begin
                do_req(1'b0, 32'h1, 32'h2, 4'b0010, 32'h3, 4'b0000, 1'b1);
                do_req(1'b0, 32'hFFFFFFFF, 32'h1, 4'b0010, 32'h0, 4'b1100, 1'b0);
            end
            begin
                do_req(1'b1, 32'd10, 32'd20, 4'b0010, 32'd30, 4'b0000, 1'b1);
                do_req(1'b1, 32'h7FFFFFFF, 32'h1, 4'b0010, 32'h80000000, 4'b0010, 1'b0);
            end
        join
        drain();
        chk("rr_count", 64'(acc_log.size()), 64'd4);
        if (acc_log.size() == 4) begin
            chk("rr_order", 64'({acc_log[0][0], acc_log[1][0], acc_log[2][0], acc_log[3][0]}),
                64'b0101);
            for (int i = 1; i < 4; i++)
                chk("rr_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);
        end

        // Backpressure: r0 SUB 5-5 held for 4 cycles; r1 waits without ready.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bg_done = 1'b0;
        do_req(1'b0, 32'h5, 32'h5, 4'b0110, 32'h0, 4'b1100, 1'b0);   // now in C1
        fork
            begin
                do_req(1'b1, 32'h2, 32'h2, 4'b0010, 32'h4, 4'b0000, 1'b0);
                bg_done = 1'b1;
            end
        join_none
        @(negedge clk);                                  // C1
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);                              // C2..C5, rsp_ready low
            chk("bp_hold", 64'({bus.rsp_valid, bus.rsp_zero, bus.r0_ready, bus.r1_ready}),
                64'b1100);
            chk("bp_result", 64'(bus.rsp_result), 64'h0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);                                  // 5th valid cycle, handshake
        chk("bp_fifth", 64'({bus.rsp_valid, bus.rsp_zero}), 64'b11);
        for (int i = 0; i < 50 && !bg_done; i++) @(posedge clk);
        chk("bp_r1_done", 64'(bg_done), 64'd1);
        drain();

        // Reset during EXEC of an r1 op: no response, next tie to r0.
        @(posedge clk); #1;
        begin
            bit got;
            got = 1'b0;
            drive(1'b1, 1'b1, 32'h3, 32'h4, 4'b0010);
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (bus.r1_ready) got = 1'b1;
            end
            chk("rst_r1_accept", 64'(got), 64'd1);
        end
        @(posedge clk); #1;                              // EXEC
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("rst_exec");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
        acc_log.delete(); acc_cyc.delete();
        @(posedge clk); #1;
        fork
            do_req(1'b0, 32'h6, 32'h7, 4'b0010, 32'hD, 4'b0000, 1'b0);
            do_req(1'b1, 32'h0, 32'h0, 4'b0010, 32'h0, 4'b1000, 1'b0);
        join
        drain();
        chk("rst_tie_r0", 64'(acc_log.size() > 0 ? acc_log[0] : 9), 64'd0);

        // Control 0101: rejected with the check enabled, forwarded otherwise.
        @(posedge clk); #1;
`ifdef ALU_ARB_OPCHECK_EN
        do_req(1'b0, 32'hF, 32'hFFFFFFF0, 4'b0101, 32'h0, 4'b0001, 1'b0);
        @(negedge clk);                                  // C1: response here
        chk("opchk_alu_ctrl", 64'(bus.alu_ctrl), 64'h2);
        chk("opchk_alu_src1", 64'(bus.alu_src1), 64'h0);
`else
        do_req(1'b0, 32'hF, 32'hFFFFFFF0, 4'b0101, 32'hF, 4'b0000, 1'b0);
        @(negedge clk);                                  // C1: EXEC
        chk("fwd_alu_ctrl", 64'(bus.alu_ctrl), 64'h5);
        chk("fwd_exec_no_rsp", 64'(bus.rsp_valid), 64'd0);
`endif
        drain();

        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
